serial_add_sequencer: RTL and testbench
=======================================

// Module: serial_add_sequencer
// PURPOSE
//  Bit-serial add/subtract unit for the multi-cycle execute path.
//  - Time-multiplexes one FullAdder instance over WIDTH cycles, LSB first.
//  - Captures operands on a start handshake and walks the bit counter.
//  - Writes each sum bit in place, then reports carry and signed overflow.
// PARAMETERS
//  WIDTH   32  operand/result width in bits, >= 2
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      request; accepted only when busy==0
//  sub       in   1      1: a-b (b inverted, carry-in 1); 0: a+b (carry-in 0)
//  a         in   WIDTH  operand A, sampled on accepting edge only
//  b         in   WIDTH  operand B, sampled on accepting edge only
//  busy      out  1      high while in RUN
//  done      out  1      single-cycle pulse in DONE
//  sum       out  WIDTH  result; held stable from DONE until next accept
//  cout      out  1      final carry (sub: 1 = no borrow)
//  overflow  out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy, done, sum, cout, overflow
//    and the bit counter go to 0 immediately. An in-flight op is discarded.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE/DONE + start: latch a, (sub ? ~b : b) and sub. Carry reg = sub,
//    sum = 0, cnt = 0, cout/overflow = 0. Next state is RUN.
//  - IDLE without start: stay in IDLE. DONE without start: go to IDLE.
//    done lasts exactly 1 cycle.
//  - RUN, each edge: FullAdder(X=a_q[cnt], Y=b_q[cnt], C=carry).
//    Write sum[cnt]=S, carry=Co, cnt=cnt+1.
//  - RUN, edge where cnt==WIDTH-1: also cout=Co and overflow=carry^Co
//    (carry here is the pre-edge carry). Next state is DONE.
//  - Latency: done is high WIDTH clocks after the accepting edge.
//    Throughput is one op per WIDTH+1 cycles. Back-to-back start during
//    DONE is legal.
//  - start while busy: ignored, no queuing. a/b/sub changes during RUN:
//    ignored.
//  - sum shows partial bits during RUN. It is valid only at done and after.
//  - cnt width is clog2(WIDTH). cnt never wraps in RUN; it is cleared on
//    accept.
// CONFIGURATION
//  SERIAL_ADD_EARLY_TERM_EN (macro):
//  - Defined: in RUN with sub==0, check on each edge. If Co==0 and
//    a_q/b_q bits above cnt are all zero, go to DONE on that edge.
//    cout=0, overflow=0, remaining sum bits stay 0.
//    Latency becomes 1..WIDTH clocks. Early exit never fires for sub==1.
//  - Undefined: fixed WIDTH-clock latency. No zero-detect logic is
//    synthesized.
// TESTING  (WIDTH=8)
//  1. add 0x35+0x4A -> sum=0x7F, cout=0, overflow=0. done exactly 8 clk
//     after accept; busy high for 8 cycles.
//  2. add 0x7F+0x01 -> sum=0x80, cout=0, overflow=1.
//     add 0xFF+0x01 -> sum=0x00, cout=1, overflow=0.
//  3. sub 0x10-0x20 -> sum=0xF0, cout=0, overflow=0.
//     sub 0x80-0x01 -> sum=0x7F, cout=1, overflow=1.
//  4. Pulse start with new a/b at bit 3 of an op -> ignored. Original
//     result returned. start on the done cycle -> new op accepted, busy
//     next cycle.
//  5. Assert rst mid-RUN (cnt=3) -> all outputs 0 with no clock edge.
//     After release, add 0x01+0x01 -> sum=0x02 with normal latency.
//  6. With SERIAL_ADD_EARLY_TERM_EN: add 0x03+0x01 -> sum=0x04, done 3 clk
//     after accept. sub 0x03-0x01 still takes 8 clk. Without the macro:
//     0x03+0x01 takes 8 clk.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract: one full adder walked LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADD_EARLY_TERM_EN enables early exit for additions.
module FullAdder (
  input  logic X,
  input  logic Y,
  input  logic C,
  output logic S,
  output logic Co
);
  assign S  = X ^ Y ^ C;
  assign Co = (X & Y) | (C & (X ^ Y));
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic w_x;
  logic w_y;
  logic w_s;
  logic w_co;
  logic w_last;
  logic w_early;

  assign w_x    = r_a[r_cnt];
  assign w_y    = r_b[r_cnt];
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  FullAdder u_fa (
    .X  (w_x),
    .Y  (w_y),
    .C  (r_carry),
    .S  (w_s),
    .Co (w_co)
  );

`ifdef SERIAL_ADD_EARLY_TERM_EN
  logic             r_sub;
  logic [WIDTH-1:0] w_rest;

  // Operand bits strictly above the current bit; all zero means no more sum bits.
  assign w_rest  = ((r_a | r_b) >> r_cnt) >> 1;
  assign w_early = !r_sub && !w_co && (w_rest == '0) && !w_last;

  // Remember the operation kind so subtraction never exits early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (start && (r_state != S_RUN)) begin
      r_sub <= sub;
    end
  end
`else
  assign w_early = 1'b0;
`endif

  // Sequencer: accept, walk one bit per edge, report, then return to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sum[r_cnt] <= w_s;
          r_carry      <= w_co;
          if (w_last) begin
            r_cout  <= w_co;
            r_ovf   <= r_carry ^ w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_early) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at WIDTH=8.
// Expected latency of 0x03+0x01 follows SERIAL_ADD_EARLY_TERM_EN.
module tb_serial_add_sequencer;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  int lat;
  int bc;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    @(negedge clk);
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int l, output int n);
    l = 0;
    n = busy ? 1 : 0;
    while (!done && l < 20) begin
      @(posedge clk);
      #1;
      l++;
      if (!done && busy) n++;
    end
  endtask

  task automatic run_chk(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic [W-1:0] es, input logic ec,
                         input logic eo, input int el);
    int l;
    int n;
    start_op(ia, ib, isub);
    wait_done(l, n);
    chk({tag, "_lat"}, 32'(l), 32'(el));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    start_op(8'h35, 8'h4A, 1'b0);
    wait_done(lat, bc);
    chk("t1_lat", 32'(lat), 32'd8);
    chk("t1_busy", 32'(bc), 32'd8);
    chk("t1_sum", 32'(sum), 32'h7F);
    chk("t1_cout", 32'(cout), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_sum_hold", 32'(sum), 32'h7F);

    run_chk("t2a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8);
    run_chk("t2b", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8);
    run_chk("t3a", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 8);
    run_chk("t3b", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 8);

    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    sub   = 1'b0;
    lat   = 4;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("t4_lat", 32'(lat), 32'd8);
    chk("t4_sum", 32'(sum), 32'h46);
    a     = 8'h05;
    b     = 8'h06;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t4_b2b_busy", 32'(busy), 32'd1);
    chk("t4_b2b_done", 32'(done), 32'd0);
    wait_done(lat, bc);
    chk("t4_b2b_lat", 32'(lat), 32'd8);
    chk("t4_b2b_sum", 32'(sum), 32'h0B);

    start_op(8'hAA, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_partial", 32'(sum), 32'h03);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_sum", 32'(sum), 32'd0);
    chk("t5_rst_cout", 32'(cout), 32'd0);
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_chk("t5_after", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 8);

`ifdef SERIAL_ADD_EARLY_TERM_EN
    run_chk("t6_add", 8'h03, 8'h01, 1'b0, 8'h04, 1'b0, 1'b0, 3);
`else
    run_chk("t6_add", 8'h03, 8'h01, 1'b0, 8'h04, 1'b0, 1'b0, 8);
`endif
    run_chk("t6_sub", 8'h03, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0, 8);

    @(posedge clk);
    #1;
    chk("end_idle_busy", 32'(busy), 32'd0);
    chk("end_idle_done", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
